tof_i2c_sequencer: RTL and testbench
====================================

# tof_i2c_sequencer

Command sequencer that sits directly upstream of the ToF I2C master driver. It walks a small command table held in an external synchronous ROM/RAM, presents each entry to the I2C driver's transaction inputs, and runs the start/ready handshake. It applies a per-transaction timeout with bounded retry, and returns read results to the ToF control logic. It runs on the same clock as the I2C driver, rising edge only.

## Interface
- SLAVE_ADDR, 7'h29, 7-bit I2C address driven on every transaction
- CMD_AW, 4, command table address width; table depth 2^CMD_AW
- TIMEOUT_CYCLES, 100000, max clocks per transaction phase before timeout
- MAX_RETRIES, 3, retries per command after the first attempt
- Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- go  in  1  start the sequence at table entry 0; sampled only in IDLE
- busy  out  1  high in every state except IDLE, DONE and ERROR
- done  out  1  one-cycle pulse when the last command completes
- error  out  1  sticky; set on retry exhaustion, cleared by the next accepted go or by reset
- cmd_addr  out  CMD_AW  table read address
- cmd_data  in  32  table word, valid 1 cycle after cmd_addr. Fields: [31] last, [30] is_read, [25:24] nb_bytes, [23:8] register address, [7:0] write data
- i2c_slave_address  out  7  constant SLAVE_ADDR
- i2c_register_address  out  16  from cmd_data[23:8]
- i2c_is_read  out  1  from cmd_data[30]
- i2c_nb_of_bytes  out  10  zero-extended nb_bytes; 0 is mapped to 1
- i2c_data_in  out  8  from cmd_data[7:0]
- i2c_start  out  1  transaction request
- i2c_reset  out  1  driver reset
- i2c_ready  in  1  driver idle/complete
- i2c_error  in  1  driver error flag
- i2c_data_out  in  16  driver read data
- rd_valid  out  1  one-cycle pulse; rd_data and rd_index are valid
- rd_data  out  16  read result
- rd_index  out  CMD_AW  table index of that read

## Operation
- States: IDLE, FETCH, LOAD, ISSUE, WAIT, CAPTURE, NEXT, RECOVER, DONE, ERROR.
- IDLE: go=1 clears error, the index and the retry count, then moves to FETCH. go is ignored in all other states.
- FETCH: drive cmd_addr = index for one cycle, then go to LOAD.
- LOAD: latch the cmd_data fields into the i2c_* output registers and clear the timeout counter, then go to ISSUE.
- ISSUE: i2c_start=1 until i2c_ready is sampled 0 (request accepted). Then i2c_start=0, clear the timeout counter, and go to WAIT.
- WAIT: on i2c_ready=1, go to CAPTURE.
- CAPTURE: if is_read, register rd_data=i2c_data_out and rd_index=index, and pulse rd_valid. Then go to NEXT.
- NEXT: if the last bit is set or index = 2^CMD_AW-1, go to DONE. Otherwise increment index, clear the retry count, and go to FETCH.
- Failure: i2c_error=1 in ISSUE or WAIT, or timeout counter = TIMEOUT_CYCLES-1, sends the block to RECOVER.
- RECOVER: i2c_reset=1 and i2c_start=0 for exactly 2 cycles. If the retry count < MAX_RETRIES, increment it and go to LOAD (same command). Otherwise go to ERROR.
- DONE: done=1 for one cycle, then go to IDLE.
- ERROR: error=1 and i2c_* held stable. go=1 restarts as from IDLE.
- Timeout counter: 17 bits minimum, saturating; counts only in ISSUE and WAIT.

## Timing
- All outputs are registered.
- Reset values: busy=0, done=0, error=0, rd_valid=0, rd_data=0, rd_index=0, cmd_addr=0, i2c_start=0, i2c_reset=1, all other i2c_* = 0 except i2c_slave_address=SLAVE_ADDR. State = IDLE.
- i2c_reset falls the first cycle after reset is released.
- Latency: go sampled at edge N gives cmd_addr valid after N, cmd_data latched at N+2, and i2c_start=1 after N+2.
- A completed transaction (i2c_ready high at edge M) produces rd_valid after M+1, then the next i2c_start no earlier than after M+4.
- Reset asserted mid-transaction: the block returns to reset values on the next edge. No done, no rd_valid.
- Simultaneous i2c_ready=1 and i2c_error=1 in WAIT: error wins, and the block goes to RECOVER.

## Test plan
- 3-entry table (write 0x7FFF←0x00, write 0x0009←0x04, read 2 bytes @0x0000, last=1), driver model responds in 20 cycles -> three start/ready handshakes; one rd_valid with rd_data equal to the model value (0xF002) and rd_index=2; done pulses once; error=0.
- Driver never drops i2c_ready after the start request, TIMEOUT_CYCLES=50 -> 4 attempts, each followed by 2 cycles of i2c_reset; then error=1, busy=0, no done.
- i2c_error on the first attempt only -> 1 RECOVER, second attempt succeeds; sequence completes with done and error=0.
- Table with no last bit, CMD_AW=2 -> exactly 4 transactions (indices 0..3), then done.
- reset pulsed while in WAIT -> next cycle busy=0, i2c_start=0, i2c_reset=1; a later go restarts at index 0.
- go held high throughout -> no restart mid-sequence; after DONE, a new sequence starts from IDLE.

Source files
------------

// File: rtl/tof_i2c_sequencer_if.sv
// Transaction bus between the command sequencer and the ToF I2C master driver.
interface tof_i2c_sequencer_if;
    logic [6:0]  i2c_slave_address;
    logic [15:0] i2c_register_address;
    logic        i2c_is_read;
    logic [9:0]  i2c_nb_of_bytes;
    logic [7:0]  i2c_data_in;
    logic        i2c_start;
    logic        i2c_reset;
    logic        i2c_ready;
    logic        i2c_error;
    logic [15:0] i2c_data_out;

    modport master (
        output i2c_slave_address, i2c_register_address, i2c_is_read, i2c_nb_of_bytes,
        output i2c_data_in, i2c_start, i2c_reset,
        input  i2c_ready, i2c_error, i2c_data_out
    );

    modport slave (
        input  i2c_slave_address, i2c_register_address, i2c_is_read, i2c_nb_of_bytes,
        input  i2c_data_in, i2c_start, i2c_reset,
        output i2c_ready, i2c_error, i2c_data_out
    );
endinterface

// File: rtl/tof_i2c_sequencer.sv
// Walks an external command table and drives the ToF I2C master one transaction at a time,
// with per-phase timeout, bounded retry through a driver reset, and read-result return.
module tof_i2c_sequencer #(
    parameter logic [6:0] SLAVE_ADDR     = 7'h29,
    parameter int         CMD_AW         = 4,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         MAX_RETRIES    = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                go,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [CMD_AW-1:0]   cmd_addr,
    input  logic [31:0]         cmd_data,
    output logic                rd_valid,
    output logic [15:0]         rd_data,
    output logic [CMD_AW-1:0]   rd_index,
    tof_i2c_sequencer_if.master i2c
);
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 17) ? $clog2(TIMEOUT_CYCLES + 1) : 17;
    localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRIES);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_LOAD    = 4'd2;
    localparam logic [3:0] S_ISSUE   = 4'd3;
    localparam logic [3:0] S_WAIT    = 4'd4;
    localparam logic [3:0] S_CAPTURE = 4'd5;
    localparam logic [3:0] S_NEXT    = 4'd6;
    localparam logic [3:0] S_RECOVER = 4'd7;
    localparam logic [3:0] S_DONE    = 4'd8;
    localparam logic [3:0] S_ERROR   = 4'd9;

    logic [3:0]        state_q, state_d;
    logic [CMD_AW-1:0] idx_q, idx_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [TW-1:0]     tcnt_q, tcnt_d, tcnt_inc;
    logic              rec_q, rec_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [CMD_AW-1:0] cmd_addr_q, cmd_addr_d;
    logic              rd_valid_q, rd_valid_d;
    logic [15:0]       rd_data_q, rd_data_d;
    logic [CMD_AW-1:0] rd_index_q, rd_index_d;
    logic              start_q, start_d, i2c_reset_q, i2c_reset_d;
    logic [15:0]       reg_addr_q, reg_addr_d;
    logic              is_read_q, is_read_d;
    logic [9:0]        nb_q, nb_d;
    logic [7:0]        din_q, din_d;
    logic              fail;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        retry_d     = retry_q;
        tcnt_d      = tcnt_q;
        rec_d       = rec_q;
        last_d      = last_q;
        error_d     = error_q;
        cmd_addr_d  = cmd_addr_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        rd_index_d  = rd_index_q;
        start_d     = start_q;
        i2c_reset_d = 1'b0;
        reg_addr_d  = reg_addr_q;
        is_read_d   = is_read_q;
        nb_d        = nb_q;
        din_d       = din_q;
        tcnt_inc    = (tcnt_q == '1) ? tcnt_q : tcnt_q + 1'b1;
        // driver error outranks a simultaneous ready
        fail        = i2c.i2c_error || (tcnt_q == T_LAST);

        case (state_q)
            S_IDLE, S_ERROR: begin
                if (go) begin
                    error_d    = 1'b0;
                    idx_d      = '0;
                    retry_d    = '0;
                    cmd_addr_d = '0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                last_d     = cmd_data[31];
                is_read_d  = cmd_data[30];
                nb_d       = (cmd_data[25:24] == 2'd0) ? 10'd1 : {8'd0, cmd_data[25:24]};
                reg_addr_d = cmd_data[23:8];
                din_d      = cmd_data[7:0];
                tcnt_d     = '0;
                start_d    = 1'b1;
                state_d    = S_ISSUE;
            end
            S_ISSUE, S_WAIT: begin
                tcnt_d = tcnt_inc;
                if (fail) begin
                    start_d     = 1'b0;
                    i2c_reset_d = 1'b1;
                    rec_d       = 1'b0;
                    state_d     = S_RECOVER;
                end else if (state_q == S_ISSUE && !i2c.i2c_ready) begin
                    start_d = 1'b0;
                    tcnt_d  = '0;
                    state_d = S_WAIT;
                end else if (state_q == S_WAIT && i2c.i2c_ready) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (is_read_q) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = i2c.i2c_data_out;
                    rd_index_d = idx_q;
                end
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (last_q || idx_q == '1) begin
                    state_d = S_DONE;
                end else begin
                    idx_d      = idx_q + 1'b1;
                    cmd_addr_d = idx_q + 1'b1;
                    retry_d    = '0;
                    state_d    = S_FETCH;
                end
            end
            S_RECOVER: begin
                // i2c_reset spans the entry cycle plus one more
                if (!rec_q) begin
                    rec_d       = 1'b1;
                    i2c_reset_d = 1'b1;
                end else if (retry_q < R_MAX) begin
                    retry_d = retry_q + 1'b1;
                    state_d = S_LOAD;
                end else begin
                    error_d = 1'b1;
                    state_d = S_ERROR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = !(state_d == S_IDLE || state_d == S_DONE || state_d == S_ERROR);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            retry_q     <= '0;
            tcnt_q      <= '0;
            rec_q       <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cmd_addr_q  <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_index_q  <= '0;
            start_q     <= 1'b0;
            i2c_reset_q <= 1'b1;
            reg_addr_q  <= '0;
            is_read_q   <= 1'b0;
            nb_q        <= '0;
            din_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            retry_q     <= retry_d;
            tcnt_q      <= tcnt_d;
            rec_q       <= rec_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cmd_addr_q  <= cmd_addr_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            rd_index_q  <= rd_index_d;
            start_q     <= start_d;
            i2c_reset_q <= i2c_reset_d;
            reg_addr_q  <= reg_addr_d;
            is_read_q   <= is_read_d;
            nb_q        <= nb_d;
            din_q       <= din_d;
        end
    end

    assign busy                     = busy_q;
    assign done                     = done_q;
    assign error                    = error_q;
    assign cmd_addr                 = cmd_addr_q;
    assign rd_valid                 = rd_valid_q;
    assign rd_data                  = rd_data_q;
    assign rd_index                 = rd_index_q;
    assign i2c.i2c_slave_address    = SLAVE_ADDR;
    assign i2c.i2c_register_address = reg_addr_q;
    assign i2c.i2c_is_read          = is_read_q;
    assign i2c.i2c_nb_of_bytes      = nb_q;
    assign i2c.i2c_data_in          = din_q;
    assign i2c.i2c_start            = start_q;
    assign i2c.i2c_reset            = i2c_reset_q;
endmodule

// File: tb/tb_tof_i2c_sequencer.sv
// Directed bench: table ROM, 20-cycle I2C driver model, and event counters sampled pre-edge.
module tb_tof_i2c_sequencer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic        busy, done, error, rd_valid;
    logic [1:0]  cmd_addr, rd_index;
    logic [31:0] cmd_data;
    logic [15:0] rd_data;
    logic [31:0] rom [4];

    int n_chk = 0, n_pass = 0;
    int n_start = 0, n_rstc = 0, n_done = 0, n_rd = 0;
    logic        start_prev = 1'b0;
    logic [15:0] last_rd_data = '0;
    logic [1:0]  last_rd_index = '0;
    bit          stuck = 1'b0;
    int          err_inject = 0, err_used = 0, busy_cnt = 0;
    int          s_start, s_rstc, s_done, s_rd;

    tof_i2c_sequencer_if bus();

    tof_i2c_sequencer #(.SLAVE_ADDR(7'h29), .CMD_AW(2), .TIMEOUT_CYCLES(50), .MAX_RETRIES(3)) dut (
        .clock(clock), .reset(reset), .go(go), .busy(busy), .done(done), .error(error),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_index(rd_index), .i2c(bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cmd_data <= rom[cmd_addr];

    always @(negedge clock) begin
        if (reset || bus.i2c_reset) begin
            bus.i2c_ready = 1'b1;
            bus.i2c_error = 1'b0;
            busy_cnt = 0;
        end else if (busy_cnt != 0) begin
            busy_cnt--;
            if (busy_cnt == 0) bus.i2c_ready = 1'b1;
        end else if (bus.i2c_start && bus.i2c_ready && !stuck) begin
            if (err_used < err_inject) begin
                bus.i2c_error = 1'b1;
                err_used++;
            end else begin
                bus.i2c_ready = 1'b0;
                busy_cnt = 20;
            end
        end
    end

    always @(posedge clock) begin
        if (!reset) begin
            if (bus.i2c_start && !start_prev) n_start++;
            if (bus.i2c_reset) n_rstc++;
            if (done) n_done++;
            if (rd_valid) begin
                n_rd++;
                last_rd_data = rd_data;
                last_rd_index = rd_index;
            end
        end
        start_prev = bus.i2c_start;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic snap();
        s_start = n_start; s_rstc = n_rstc; s_done = n_done; s_rd = n_rd;
    endtask

    task automatic pulse_go();
        @(negedge clock) go = 1'b1;
        @(negedge clock) go = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (!busy) begin ok = 1'b1; break; end
        end
        check(tag, 32'(ok), 32'd1);
        repeat (3) @(negedge clock);
    endtask

    task automatic load_table1();
        rom[0] = 32'h007FFF00;
        rom[1] = 32'h01000904;
        rom[2] = 32'hC2000000;
        rom[3] = 32'h00000000;
    endtask

    initial begin
        bus.i2c_data_out = 16'hF002;
        load_table1();
        repeat (3) @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_cmd_addr", 32'(cmd_addr), 32'd0);
        check("rst_start", 32'(bus.i2c_start), 32'd0);
        check("rst_i2c_reset", 32'(bus.i2c_reset), 32'd1);
        check("rst_slave_addr", 32'(bus.i2c_slave_address), 32'h29);
        reset = 1'b0;
        @(negedge clock);
        check("i2c_reset_fall", 32'(bus.i2c_reset), 32'd0);

        // 3-entry table, read on the last entry
        snap();
        pulse_go();
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_cmd_addr", 32'(cmd_addr), 32'd0);
        @(negedge clock);
        check("t1_start_n1", 32'(bus.i2c_start), 32'd0);
        @(negedge clock);
        check("t1_start_n2", 32'(bus.i2c_start), 32'd1);
        check("t1_reg_addr", 32'(bus.i2c_register_address), 32'h7FFF);
        check("t1_nb_zero_map", 32'(bus.i2c_nb_of_bytes), 32'd1);
        check("t1_is_read", 32'(bus.i2c_is_read), 32'd0);
        wait_idle("t1_finish");
        check("t1_starts", 32'(n_start - s_start), 32'd3);
        check("t1_rd_count", 32'(n_rd - s_rd), 32'd1);
        check("t1_rd_data", 32'(last_rd_data), 32'hF002);
        check("t1_rd_index", 32'(last_rd_index), 32'd2);
        check("t1_done", 32'(n_done - s_done), 32'd1);
        check("t1_error", 32'(error), 32'd0);
        check("t1_nb_last", 32'(bus.i2c_nb_of_bytes), 32'd2);

        // driver error on the first attempt only
        snap();
        err_inject = 1;
        pulse_go();
        wait_idle("t2_finish");
        check("t2_starts", 32'(n_start - s_start), 32'd4);
        check("t2_rst_cycles", 32'(n_rstc - s_rstc), 32'd2);
        check("t2_done", 32'(n_done - s_done), 32'd1);
        check("t2_error", 32'(error), 32'd0);

        // driver never accepts: 4 attempts then sticky error
        snap();
        stuck = 1'b1;
        pulse_go();
        wait_idle("t3_finish");
        check("t3_starts", 32'(n_start - s_start), 32'd4);
        check("t3_rst_cycles", 32'(n_rstc - s_rstc), 32'd8);
        check("t3_error", 32'(error), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_done", 32'(n_done - s_done), 32'd0);
        stuck = 1'b0;

        // no last bit: runs off the end of a 4-entry table
        rom[0] = 32'h00000011;
        rom[1] = 32'h01000022;
        rom[2] = 32'h02000033;
        rom[3] = 32'h40123400;
        snap();
        pulse_go();
        check("t4_error_cleared", 32'(error), 32'd0);
        wait_idle("t4_finish");
        check("t4_starts", 32'(n_start - s_start), 32'd4);
        check("t4_done", 32'(n_done - s_done), 32'd1);
        check("t4_rd_index", 32'(last_rd_index), 32'd3);
        check("t4_reg_addr", 32'(bus.i2c_register_address), 32'h1234);

        // reset while waiting on the driver
        pulse_go();
        begin
            bit in_wait = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clock);
                if (busy && !bus.i2c_start && !bus.i2c_ready) begin in_wait = 1'b1; break; end
            end
            check("t5_reached_wait", 32'(in_wait), 32'd1);
        end
        repeat (3) @(negedge clock);
        snap();
        reset = 1'b1;
        @(negedge clock);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_start", 32'(bus.i2c_start), 32'd0);
        check("t5_i2c_reset", 32'(bus.i2c_reset), 32'd1);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("t5_no_done", 32'(n_done - s_done), 32'd0);
        check("t5_no_rd", 32'(n_rd - s_rd), 32'd0);
        snap();
        pulse_go();
        check("t5_restart_addr", 32'(cmd_addr), 32'd0);
        wait_idle("t5_finish");
        check("t5_starts", 32'(n_start - s_start), 32'd4);
        check("t5_done", 32'(n_done - s_done), 32'd1);

        // go held high through a whole sequence
        load_table1();
        snap();
        @(negedge clock) go = 1'b1;
        begin
            bit saw_done = 1'b0;
            for (int i = 0; i < 500; i++) begin
                @(negedge clock);
                if (done) begin saw_done = 1'b1; break; end
            end
            check("t6_done_seen", 32'(saw_done), 32'd1);
        end
        check("t6_no_restart", 32'(n_start - s_start), 32'd3);
        @(negedge clock);
        check("t6_idle_gap", 32'(busy), 32'd0);
        @(negedge clock);
        check("t6_restart_busy", 32'(busy), 32'd1);
        check("t6_restart_addr", 32'(cmd_addr), 32'd0);
        go = 1'b0;
        wait_idle("t6_finish");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
